// File: rtl/iq_frame_packer.sv
// rtl/iq_frame_packer.sv - ping-pong frame buffer replaying a 1-sample IQ stream as gap-free 2-sample bursts
// Writer packs sample pairs into the fill bank; reader replays each full bank as NB consecutive beats.
module iq_frame_packer #(
  parameter int BW     = 16,
  parameter int L2_IMG = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_vld,
  output logic            s_rdy,
  input  logic [2*BW-1:0] s_data,
  input  logic            s_last,
  output logic            vld_out,
  output logic [4*BW-1:0] data_out,
  output logic            frame_sof,
  output logic            frame_err
);
  localparam int NB = 2 ** (L2_IMG - 1);
  localparam int AW = L2_IMG - 1;
  localparam logic [L2_IMG-1:0] WCNT_MAX  = '1;
  localparam logic [AW-1:0]     RADDR_MAX = '1;

  typedef enum logic {ST_IDLE, ST_BURST} rd_state_t;

  logic [4*BW-1:0]   mem [0:2*NB-1];
  logic [L2_IMG-1:0] wcnt;
  logic              wb;
  logic [1:0]        full;
  logic [2*BW-1:0]   held;
  rd_state_t         rd_state;
  logic              rb;
  logic [AW-1:0]     raddr;

  logic       xfer;
  logic       bad_last;
  logic       frame_done;
  logic       wr_en;
  logic       rd_clear;
  logic [1:0] full_nxt;
  logic       wb_nxt;

  // Clear and set always hit different banks: the writer never fills a bank the reader owns.
  always_comb begin
    xfer       = s_vld && s_rdy;
    bad_last   = xfer && s_last && (wcnt != WCNT_MAX);
    frame_done = xfer && (wcnt == WCNT_MAX);
    wr_en      = xfer && wcnt[0] && !bad_last;
    rd_clear   = (rd_state == ST_BURST) && (raddr == RADDR_MAX);
    full_nxt   = full;
    if (rd_clear)   full_nxt[rb] = 1'b0;
    if (frame_done) full_nxt[wb] = 1'b1;
    wb_nxt     = frame_done ? ~wb : wb;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wb, wcnt[L2_IMG-1:1]}] <= {held, s_data};
  end

  // s_rdy is computed from next-state flags so no transfer can ever land in a full bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt      <= '0;
      wb        <= 1'b0;
      full      <= 2'b00;
      held      <= '0;
      s_rdy     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      full      <= full_nxt;
      wb        <= wb_nxt;
      s_rdy     <= !full_nxt[wb_nxt];
      frame_err <= bad_last || (frame_done && !s_last);
      if (xfer) begin
        if (!wcnt[0]) held <= s_data;
        wcnt <= bad_last ? '0 : wcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state  <= ST_IDLE;
      rb        <= 1'b0;
      raddr     <= '0;
      vld_out   <= 1'b0;
      data_out  <= '0;
      frame_sof <= 1'b0;
    end else begin
      vld_out   <= 1'b0;
      frame_sof <= 1'b0;
      case (rd_state)
        ST_IDLE: begin
          if (full != 2'b00) begin
            rd_state <= ST_BURST;
            rb       <= !full[0];
            raddr    <= '0;
          end
        end
        ST_BURST: begin
          data_out  <= mem[{rb, raddr}];
          vld_out   <= 1'b1;
          frame_sof <= (raddr == '0);
          raddr     <= raddr + 1'b1;
          // raddr wraps to 0, so a waiting bank restarts with no idle cycle
          if (raddr == RADDR_MAX) begin
            if (full[~rb]) rb <= ~rb;
            else           rd_state <= ST_IDLE;
          end
        end
        default: rd_state <= ST_IDLE;
      endcase
    end
  end

endmodule
